// File: rtl/core_sequencer_if.sv
// Memory-side handshake bundle of the core sequencer: instruction fetch and data access.
// The core owns the requests and address; the memory owns the valid/data responses.
interface core_sequencer_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_rvalid_i;

  modport master (
    output imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o,
    input  imem_rvalid_i, imem_rdata_i, dmem_rvalid_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o,
    output imem_rvalid_i, imem_rdata_i, dmem_rvalid_i
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// one-hot type enables, PC update and a sticky trap for illegal/misaligned/timeout faults.
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  core_sequencer_if.master bus,
  output logic [31:0]      instr_o,
  output logic             R_EN_o,
  output logic             I_EN_o,
  output logic             S_EN_o,
  output logic             SB_EN_o,
  output logic             U_EN_o,
  output logic             UJ_EN_o,
  output logic             DR_EN_o,
  output logic             DWR_EN_o,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic             reg_we_o,
  output logic [31:0]      pc_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q, instr_q;
  logic [5:0]  en_q;        // {R, I, S, SB, U, UJ}
  logic        dr_q, dwr_q;
  logic        imem_req_q, dmem_req_q, dmem_we_q, reg_we_q;
  logic        go_q;        // fetch request already issued in this FETCH visit
  logic [7:0]  wait_q;
  logic        trap_q;
  logic [1:0]  cause_q;

  logic [5:0]  dec_en_d;
  logic        dec_dr_d, dec_dwr_d;
  logic [31:0] pc_inc_d;
  logic        redirect_d, misalign_d, wb_we_d;

  always_comb begin
    dec_en_d  = 6'b000000;
    dec_dr_d  = 1'b0;
    dec_dwr_d = 1'b0;
    case (bus.imem_rdata_i[6:0])
      OP_R:                  dec_en_d = 6'b100000;
      OP_IMM, OP_JALR:       dec_en_d = 6'b010000;
      OP_LOAD: begin
        dec_en_d = 6'b010000;
        dec_dr_d = 1'b1;
      end
      OP_STORE: begin
        dec_en_d  = 6'b001000;
        dec_dwr_d = 1'b1;
      end
      OP_BR:                 dec_en_d = 6'b000100;
      OP_LUI, OP_AUIPC:      dec_en_d = 6'b000010;
      OP_JAL:                dec_en_d = 6'b000001;
      default:               dec_en_d = 6'b000000;
    endcase
    pc_inc_d   = pc_q + 32'd4;
    redirect_d = (en_q[2] | en_q[0] | (instr_q[6:0] == OP_JALR)) & branch_taken_i;
    misalign_d = redirect_d & (branch_target_i[1:0] != 2'b00);
    wb_we_d    = en_q[5] | en_q[4] | en_q[1] | en_q[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      en_q       <= 6'b000000;
      dr_q       <= 1'b0;
      dwr_q      <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      go_q       <= 1'b0;
      wait_q     <= 8'd0;
      trap_q     <= 1'b0;
      cause_q    <= 2'b00;
    end else begin
      case (state_q)
        FETCH: begin
          if (!go_q) begin
            imem_req_q <= 1'b1;
            go_q       <= 1'b1;
          end else begin
            imem_req_q <= 1'b0;
            if (bus.imem_rvalid_i) begin
              instr_q <= bus.imem_rdata_i;
              en_q    <= dec_en_d;
              dr_q    <= dec_dr_d;
              dwr_q   <= dec_dwr_d;
              go_q    <= 1'b0;
              state_q <= DECODE;
            end else if (wait_q == TO_LAST) begin
              go_q    <= 1'b0;
              trap_q  <= 1'b1;
              cause_q <= 2'b11;
              state_q <= TRAP;
            end else begin
              wait_q <= wait_q + 8'd1;
            end
          end
        end
        DECODE: begin
          // An unrecognised opcode decoded to all-zero enables
          if (en_q == 6'b000000) begin
            trap_q  <= 1'b1;
            cause_q <= 2'b01;
            state_q <= TRAP;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (dr_q | dwr_q) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= dwr_q;
            wait_q     <= 8'd0;
            state_q    <= MEM;
          end else begin
            reg_we_q <= wb_we_d;
            state_q  <= WB;
          end
        end
        MEM: begin
          if (bus.dmem_rvalid_i) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= wb_we_d;
            state_q    <= WB;
          end else if (wait_q == TO_LAST) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            en_q       <= 6'b000000;
            dr_q       <= 1'b0;
            dwr_q      <= 1'b0;
            trap_q     <= 1'b1;
            cause_q    <= 2'b11;
            state_q    <= TRAP;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        WB: begin
          reg_we_q <= 1'b0;
          en_q     <= 6'b000000;
          dr_q     <= 1'b0;
          dwr_q    <= 1'b0;
          if (misalign_d) begin
            trap_q  <= 1'b1;
            cause_q <= 2'b10;
            state_q <= TRAP;
          end else begin
            pc_q       <= redirect_d ? branch_target_i : pc_inc_d;
            imem_req_q <= 1'b1;
            go_q       <= 1'b1;
            wait_q     <= 8'd0;
            state_q    <= FETCH;
          end
        end
        TRAP:    state_q <= TRAP;
        default: state_q <= TRAP;
      endcase
    end
  end

  assign bus.imem_req_o  = imem_req_q;
  assign bus.imem_addr_o = pc_q;
  assign bus.dmem_req_o  = dmem_req_q;
  assign bus.dmem_we_o   = dmem_we_q;
  assign instr_o         = instr_q;
  assign {R_EN_o, I_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o} = en_q;
  assign DR_EN_o         = dr_q;
  assign DWR_EN_o        = dwr_q;
  assign reg_we_o        = reg_we_q;
  assign pc_o            = pc_q;
  assign trap_o          = trap_q;
  assign trap_cause_o    = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a table of instructions with hand-computed
// enables, strobes, latency and PC, plus sequences for reset and fetch-timeout corners.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_o;
  logic        R_EN_o, I_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o;
  logic        DR_EN_o, DWR_EN_o;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        reg_we_o;
  logic [31:0] pc_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;

  core_sequencer_if bus ();

  core_sequencer #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus),
    .instr_o        (instr_o),
    .R_EN_o         (R_EN_o),
    .I_EN_o         (I_EN_o),
    .S_EN_o         (S_EN_o),
    .SB_EN_o        (SB_EN_o),
    .U_EN_o         (U_EN_o),
    .UJ_EN_o        (UJ_EN_o),
    .DR_EN_o        (DR_EN_o),
    .DWR_EN_o       (DWR_EN_o),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .reg_we_o       (reg_we_o),
    .pc_o           (pc_o),
    .trap_o         (trap_o),
    .trap_cause_o   (trap_cause_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        taken;
    logic [31:0] tgt;
    int          delay;   // MEM cycle on which dmem_rvalid is returned
    logic [5:0]  en;      // {R,I,S,SB,U,UJ}
    logic [1:0]  drw;     // {DR,DWR}
    int          we;      // reg_we_o high cycles
    int          dmem;    // dmem_req_o high cycles
    int          dwe;     // dmem_we_o high cycles
    logic [31:0] pc;      // PC after the instruction
    logic [1:0]  cause;   // 0 = no trap expected
  } vec_t;

  localparam int NV = 17;
  vec_t        vecs [NV];
  int          nvec = 0;
  int          nmis = 0;
  logic [31:0] cur_pc;

  function automatic logic [5:0] en_now();
    return {R_EN_o, I_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.imem_rvalid_i  = 1'b0;
    bus.imem_rdata_i   = 32'h0;
    bus.dmem_rvalid_i  = 1'b0;
    branch_taken       = 1'b0;
    branch_target      = 32'h0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cur_pc = 32'h0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n, en_bad, drw_bad, we_n, dm_n, dwe_n, lat, quiet_bad;
    logic done;
    string p;
    p = $sformatf("v%0d_", idx);
    n = 0; en_bad = 0; drw_bad = 0; we_n = 0; dm_n = 0; dwe_n = 0; quiet_bad = 0;
    branch_taken  = v.taken;
    branch_target = v.tgt;
    while (!bus.imem_req_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({p, "fetch_req"}, {31'b0, bus.imem_req_o}, 32'd1);
    check({p, "fetch_addr"}, bus.imem_addr_o, cur_pc);
    if (en_now() != 6'b0) en_bad++;
    @(negedge clk);
    check({p, "req_one_cycle"}, {31'b0, bus.imem_req_o}, 32'd0);
    if (en_now() != 6'b0) en_bad++;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = v.instr;
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0000_0033;
    check({p, "instr"}, instr_o, v.instr);
    lat  = 2;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (bus.imem_req_o || trap_o) done = 1'b1;
      else begin
        lat++;
        if (en_now() != v.en) en_bad++;
        if ({DR_EN_o, DWR_EN_o} != v.drw) drw_bad++;
        if (reg_we_o) we_n++;
        if (bus.dmem_we_o) dwe_n++;
        if (bus.dmem_req_o) begin
          dm_n++;
          bus.dmem_rvalid_i = (dm_n == v.delay);
        end else bus.dmem_rvalid_i = 1'b0;
        @(negedge clk);
      end
    end
    bus.dmem_rvalid_i = 1'b0;
    check({p, "completes"}, {31'b0, done}, 32'd1);
    check({p, "enables"}, en_bad, 0);
    check({p, "dr_dwr"}, drw_bad, 0);
    check({p, "reg_we_cycles"}, we_n, v.we);
    check({p, "dmem_req_cycles"}, dm_n, v.dmem);
    check({p, "dmem_we_cycles"}, dwe_n, v.dwe);
    check({p, "pc"}, pc_o, v.pc);
    check({p, "trap"}, {31'b0, trap_o}, {31'b0, (v.cause != 2'b00)});
    check({p, "cause"}, {30'b0, trap_cause_o}, {30'b0, v.cause});
    if (v.cause == 2'b00) begin
      check({p, "latency"}, lat, 5 + v.dmem);
      cur_pc = v.pc;
    end else begin
      bus.imem_rvalid_i = 1'b1;
      bus.dmem_rvalid_i = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (bus.imem_req_o || bus.dmem_req_o || reg_we_o || en_now() != 6'b0 ||
            DR_EN_o || DWR_EN_o || !trap_o || trap_cause_o != v.cause || pc_o != v.pc)
          quiet_bad++;
      end
      check({p, "trap_absorbing"}, quiet_bad, 0);
      do_reset();
    end
  endtask

  initial begin
    int n;
    rst_n             = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.dmem_rvalid_i = 1'b0;
    branch_taken      = 1'b0;
    branch_target     = 32'h0;
    cur_pc            = 32'h0;

    vecs[0]  = '{32'h002081B3, 1'b0, 32'h0,         0, 6'b100000, 2'b00, 1, 0, 0, 32'h0000_0004, 2'b00};
    vecs[1]  = '{32'h0000A103, 1'b0, 32'h0,         3, 6'b010000, 2'b10, 1, 3, 0, 32'h0000_0008, 2'b00};
    vecs[2]  = '{32'h0020A023, 1'b0, 32'h0,         2, 6'b001000, 2'b01, 0, 2, 2, 32'h0000_000C, 2'b00};
    vecs[3]  = '{32'h00208463, 1'b1, 32'h100,       0, 6'b000100, 2'b00, 0, 0, 0, 32'h0000_0100, 2'b00};
    vecs[4]  = '{32'h00208463, 1'b0, 32'h200,       0, 6'b000100, 2'b00, 0, 0, 0, 32'h0000_0104, 2'b00};
    vecs[5]  = '{32'h00100093, 1'b1, 32'h300,       0, 6'b010000, 2'b00, 1, 0, 0, 32'h0000_0108, 2'b00};
    vecs[6]  = '{32'h000012B7, 1'b0, 32'h0,         0, 6'b000010, 2'b00, 1, 0, 0, 32'h0000_010C, 2'b00};
    vecs[7]  = '{32'h00001317, 1'b0, 32'h0,         0, 6'b000010, 2'b00, 1, 0, 0, 32'h0000_0110, 2'b00};
    vecs[8]  = '{32'h000080E7, 1'b1, 32'h40,        0, 6'b010000, 2'b00, 1, 0, 0, 32'h0000_0040, 2'b00};
    vecs[9]  = '{32'h0000006F, 1'b1, 32'hFFFFFFFC, 0, 6'b000001, 2'b00, 1, 0, 0, 32'hFFFF_FFFC, 2'b00};
    vecs[10] = '{32'h002081B3, 1'b0, 32'h0,         0, 6'b100000, 2'b00, 1, 0, 0, 32'h0000_0000, 2'b00};
    vecs[11] = '{32'h0000A103, 1'b0, 32'h0,         1, 6'b010000, 2'b10, 1, 1, 0, 32'h0000_0004, 2'b00};
    vecs[12] = '{32'h00208463, 1'b1, 32'h102,       0, 6'b000100, 2'b00, 0, 0, 0, 32'h0000_0004, 2'b10};
    vecs[13] = '{32'hFFFFFFFF, 1'b0, 32'h0,         0, 6'b000000, 2'b00, 0, 0, 0, 32'h0000_0000, 2'b01};
    vecs[14] = '{32'h0000A103, 1'b0, 32'h0,         9, 6'b010000, 2'b10, 0, 4, 0, 32'h0000_0000, 2'b11};
    vecs[15] = '{32'h0000006F, 1'b1, 32'h201,       0, 6'b000001, 2'b00, 1, 0, 0, 32'h0000_0000, 2'b10};
    vecs[16] = '{32'h002081B3, 1'b0, 32'h0,         0, 6'b100000, 2'b00, 1, 0, 0, 32'h0000_0004, 2'b00};

    // Reset state while rst_n is held low
    #3;
    check("rst_outputs",
          {28'b0, bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, reg_we_o}, 32'h0);
    check("rst_enables", {22'b0, en_now(), DR_EN_o, DWR_EN_o, trap_o, 1'b0}, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_cause", {30'b0, trap_cause_o}, 32'h0);
    do_reset();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Fetch timeout: no instruction ever returned; stray dmem_rvalid is ignored
    do_reset();
    n = 0;
    while (!bus.imem_req_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.dmem_rvalid_i = 1'b1;
    n = 0;
    while (!trap_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_timeout_cycles", n, 4);
    check("fetch_timeout_cause", {30'b0, trap_cause_o}, 32'd3);
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h002081B3;
    repeat (3) @(negedge clk);
    check("timeout_trap_holds", {29'b0, trap_o, bus.imem_req_o, bus.dmem_req_o}, 32'h4);
    check("timeout_instr_kept", instr_o, 32'h0);

    // Asynchronous reset while a load waits in MEM
    do_reset();
    n = 0;
    while (!bus.imem_req_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'h0000A103;
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    n = 0;
    while (!bus.dmem_req_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("mem_req_before_reset", {31'b0, bus.dmem_req_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_drop_dmem_req", {31'b0, bus.dmem_req_o}, 32'd0);
    check("async_pc", pc_o, 32'h0);
    check("async_instr", instr_o, 32'h0);
    check("async_enables", {24'b0, en_now(), DR_EN_o, DWR_EN_o}, 32'h0);
    @(negedge clk);
    check("req_low_in_reset", {31'b0, bus.imem_req_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req_after_reset", {31'b0, bus.imem_req_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
